// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serialiser (8N1 by default).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  wr_data,
    input  logic                        wr_en,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        busy,
    output logic                        tx
);

    localparam int DIV_RAW = CLK_FREQ / BAUD;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int CNT_W   = $clog2(DIV);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             tx_q, tx_d;
    logic             overflow_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;

    logic             full_w, empty_w, wr_accept, pop, baud_wrap;

    assign full_w    = (count_q == DEPTH_C);
    assign empty_w   = (count_q == '0);
    assign wr_accept = wr_en && !full_w;
    assign baud_wrap = (baud_q == DIV_LAST);

    // ------------------------------------------------------------------ FIFO
    // NOTE: the data array carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        // NOTE: assign every combinational output a default first so no latch is inferred.
        count_d = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= wr_en && full_w;
        end
    end

    // ------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

    // ------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        pop     = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!empty_w) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = ST_START;
                    baud_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (baud_wrap) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_wrap) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Chain straight into the next frame when data is waiting.
                if (baud_wrap) begin
                    if (!empty_w) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------- FSM: output
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = ^shift_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign tx       = tx_q;

endmodule
